// File: rtl/data_bus_pkg.sv
// Shared definitions for the data bus responder: FSM state encoding,
// MMIO address map, RAM geometry and small decode/merge helpers.
package data_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Which resource a captured request is aimed at.
    typedef enum logic [2:0] {
        TGT_RAM  = 3'd0,
        TGT_LED  = 3'd1,
        TGT_CYC  = 3'd2,
        TGT_TXN  = 3'd3,
        TGT_NONE = 3'd4
    } target_t;

    localparam logic [7:0] LED_ADDR   = 8'hF0;
    localparam logic [7:0] CYC_ADDR   = 8'hF4;
    localparam logic [7:0] TXN_ADDR   = 8'hF8;
    localparam int         RAM_WORDS  = 60;
    localparam int         WORD_IDX_W = 6;

    // Map a word index (address bits [7:2]) to its target. Any set address
    // bit above bit 7 makes the access unmapped regardless of the low bits.
    function automatic target_t decode_target(input logic [WORD_IDX_W-1:0] word_idx,
                                              input logic                  upper_nz);
        target_t tgt;
        tgt = TGT_NONE;
        if (!upper_nz) begin
            if (word_idx < WORD_IDX_W'(RAM_WORDS)) begin
                tgt = TGT_RAM;
            end else if (word_idx == LED_ADDR[7:2]) begin
                tgt = TGT_LED;
            end else if (word_idx == CYC_ADDR[7:2]) begin
                tgt = TGT_CYC;
            end else if (word_idx == TXN_ADDR[7:2]) begin
                tgt = TGT_TXN;
            end
        end
        return tgt;
    endfunction

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/responder_ram.sv
// 60 x 32-bit synchronous RAM with per-byte write enables. Contents are
// deliberately never reset; read data appears the cycle after a read strobe.
module responder_ram
    import data_bus_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [WORD_IDX_W-1:0] addr,
    input  logic [3:0]            be,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:RAM_WORDS-1];

    // Byte-lane writes and registered reads; the controller never reads and
    // writes in the same cycle, so no read-during-write policy is needed.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_bus_responder.sv
// Single-outstanding bus responder: accepts one request in IDLE, waits a
// fixed number of cycles, then issues a one-cycle response. Fronts a small
// RAM plus LED, cycle-counter and transaction-counter registers.
// ADDR_WIDTH must be at least 8.
module data_bus_responder
    import data_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [3:0]            req_be,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [7:0]            leds
);

    // Wait counter is loaded with WAIT_STATES-1 so WAIT lasts WAIT_STATES cycles.
    localparam int WS_INIT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    state_t                state;
    logic [3:0]            wait_cnt;
    logic                  cap_we;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [3:0]            cap_be;
    logic [31:0]           cap_wdata;

    logic [31:0]           led_reg;
    logic [31:0]           cyc_cnt;
    logic [31:0]           txn_cnt;

    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [31:0]           rsp_mmio_q;
    logic                  rsp_sel_ram_q;

    logic                  act_we;
    logic [ADDR_WIDTH-1:0] act_addr;
    logic [3:0]            act_be;
    logic [31:0]           act_wdata;
    logic                  upper_nz;
    target_t               act_tgt;
    logic                  handshake;
    logic                  enter_resp;
    logic [31:0]           mmio_value;
    logic                  ram_we;
    logic                  ram_re;
    logic [31:0]           ram_rdata;
    logic                  unused_addr_bits;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign handshake = req_valid && req_ready;

    // With zero wait states the commit edge is also the capture edge, so the
    // live request fields are used while IDLE and the captured ones afterwards.
    always_comb begin
        if (state == ST_IDLE) begin
            act_we    = req_we;
            act_addr  = req_addr;
            act_be    = req_be;
            act_wdata = req_wdata;
        end else begin
            act_we    = cap_we;
            act_addr  = cap_addr;
            act_be    = cap_be;
            act_wdata = cap_wdata;
        end
    end

    generate
        if (ADDR_WIDTH > 8) begin : g_upper
            assign upper_nz = |act_addr[ADDR_WIDTH-1:8];
        end else begin : g_no_upper
            assign upper_nz = 1'b0;
        end
    endgenerate

    assign unused_addr_bits = ^act_addr[1:0];
    assign act_tgt          = decode_target(act_addr[7:2], upper_nz);

    // Marks the clock edge on which the FSM moves into RESP; writes commit
    // and read data is sampled on exactly this edge.
    always_comb begin
        enter_resp = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: enter_resp = handshake && (WAIT_STATES == 0);
                ST_WAIT: enter_resp = (wait_cnt == 4'd0);
                default: enter_resp = 1'b0;
            endcase
        end
    end

    // Read-back value for the register-mapped locations.
    always_comb begin
        mmio_value = 32'd0;
        case (act_tgt)
            TGT_LED: mmio_value = led_reg;
            TGT_CYC: mmio_value = cyc_cnt;
            TGT_TXN: mmio_value = txn_cnt;
            default: mmio_value = 32'd0;
        endcase
    end

    assign ram_we = enter_resp && act_we && (act_tgt == TGT_RAM);
    assign ram_re = enter_resp && !act_we && (act_tgt == TGT_RAM);

    responder_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (act_addr[7:2]),
        .be    (act_be),
        .wdata (act_wdata),
        .rdata (ram_rdata)
    );

    // Request FSM: capture in IDLE, count down in WAIT, pulse the response in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            wait_cnt      <= 4'd0;
            cap_we        <= 1'b0;
            cap_addr      <= '0;
            cap_be        <= 4'd0;
            cap_wdata     <= 32'd0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_mmio_q    <= 32'd0;
            rsp_sel_ram_q <= 1'b0;
        end else begin
            rsp_valid_q   <= enter_resp;
            rsp_err_q     <= enter_resp && (act_tgt == TGT_NONE);
            rsp_mmio_q    <= (enter_resp && !act_we) ? mmio_value : 32'd0;
            rsp_sel_ram_q <= ram_re;
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_be    <= req_be;
                        cap_wdata <= req_wdata;
                        if (WAIT_STATES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= 4'(WS_INIT);
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // MMIO registers: free-running cycle counter, completed-transaction
    // counter bumped on each RESP cycle, and the byte-enabled LED register.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_reg <= 32'd0;
            cyc_cnt <= 32'd0;
            txn_cnt <= 32'd0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (state == ST_RESP) begin
                txn_cnt <= txn_cnt + 32'd1;
            end
            if (enter_resp && act_we && (act_tgt == TGT_LED)) begin
                led_reg <= merge_lanes(led_reg, act_wdata, act_be);
            end
        end
    end

    assign rsp_valid = rsp_valid_q && !rst;
    assign rsp_err   = rsp_err_q && !rst;
    assign rsp_rdata = rst ? 32'd0 : (rsp_sel_ram_q ? ram_rdata : rsp_mmio_q);
    assign leds      = led_reg[7:0];

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: directed scenarios with literal
// expectations followed by randomized traffic against an address-map model.
module tb_data_bus_responder;

    localparam int AW = 10;
    localparam int WS = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [3:0]    req_be = 4'd0;
    logic [31:0]   req_wdata = 32'd0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [7:0]    leds;

    always #5 clk = ~clk;

    data_bus_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .leds      (leds)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   wdata;
        longint        hs_cycle;
        logic [31:0]   cyc_expect;
    } txn_t;

    int          checks = 0;
    int          errors = 0;
    txn_t        pending[$];
    txn_t        cur;
    logic [31:0] ram_model [64];
    logic [3:0]  ram_known [64];
    logic [31:0] led_model = 32'd0;
    logic [31:0] txn_done = 32'd0;
    logic [31:0] cyc_model = 32'd0;
    longint      abs_cycle = 0;
    int          rsp_seen = 0;
    logic [31:0] last_rdata = 32'd0;
    logic        last_err = 1'b0;
    bit          prev_rst = 1'b0;
    logic [31:0] exp_rd;
    logic        exp_err;
    bit          exp_known;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // Expected outcome of a request from the address map and the model state.
    function automatic void model_expect(input txn_t t, output logic [31:0] rd,
                                         output logic err, output bit known);
        int idx;
        bit upper;
        idx   = int'(t.addr[7:2]);
        upper = |t.addr[AW-1:8];
        rd    = 32'd0;
        err   = 1'b0;
        known = 1'b1;
        if (upper || idx == 63) begin
            err = 1'b1;
        end else if (idx < 60) begin
            rd    = ram_model[idx];
            known = (ram_known[idx] == 4'hF);
        end else if (idx == 60) begin
            rd = led_model;
        end else if (idx == 61) begin
            rd = t.cyc_expect;
        end else begin
            rd = txn_done;
        end
    endfunction

    function automatic void model_commit(input txn_t t);
        int idx;
        idx = int'(t.addr[7:2]);
        if (t.we && !(|t.addr[AW-1:8])) begin
            for (int b = 0; b < 4; b++) begin
                if (t.be[b]) begin
                    if (idx < 60) begin
                        ram_model[idx][8*b +: 8] = t.wdata[8*b +: 8];
                        ram_known[idx][b] = 1'b1;
                    end else if (idx == 60) begin
                        led_model[8*b +: 8] = t.wdata[8*b +: 8];
                    end
                end
            end
        end
    endfunction

    // Cycle bookkeeping: absolute edge count and the expected counter value.
    always @(posedge clk) begin
        abs_cycle = abs_cycle + 1;
        if (rst) cyc_model = 32'd0;
        else     cyc_model = cyc_model + 32'd1;
    end

    // Compare process: checks every output on every falling edge.
    always @(negedge clk) begin
        if (rst) begin
            pending.delete();
            led_model = 32'd0;
            txn_done  = 32'd0;
            checkOutput("rst_ready", 32'(req_ready), 32'd0);
            checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            if (prev_rst) checkOutput("rst_leds", {24'd0, leds}, 32'd0);
        end else begin
            checkOutput("ready", 32'(req_ready), 32'(pending.size() == 0));
            if (rsp_valid) begin
                if (pending.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 expected 0 at t=%0t", $time);
                end else begin
                    cur = pending.pop_front();
                    checkOutput("latency", 32'(abs_cycle - cur.hs_cycle), 32'(WS + 1));
                    model_expect(cur, exp_rd, exp_err, exp_known);
                    checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
                    if (!cur.we && exp_known) checkOutput("rsp_rdata", rsp_rdata, exp_rd);
                    model_commit(cur);
                    txn_done = txn_done + 32'd1;
                    checkOutput("leds", {24'd0, leds}, {24'd0, led_model[7:0]});
                    last_rdata = rsp_rdata;
                    last_err   = rsp_err;
                    rsp_seen++;
                end
            end else begin
                checkOutput("idle_rdata", rsp_rdata, 32'd0);
                checkOutput("idle_err", 32'(rsp_err), 32'd0);
                if (pending.size() > 0 && (abs_cycle - pending[0].hs_cycle) > longint'(WS + 1)) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rsp_timeout: got no rsp_valid expected one at t=%0t", $time);
                    void'(pending.pop_front());
                end
            end
            if (req_valid && req_ready) begin
                cur.we         = req_we;
                cur.addr       = req_addr;
                cur.be         = req_be;
                cur.wdata      = req_wdata;
                cur.hs_cycle   = abs_cycle;
                cur.cyc_expect = cyc_model + 32'(WS);
                pending.push_back(cur);
            end
        end
        prev_rst = rst;
    end

    // One request/response, bounded waits on handshake and completion.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata);
        int start;
        bit got;
        start = rsp_seen;
        got   = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wdata;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout: got req_ready=0 expected 1");
        end
        for (int i = 0; i < 20 && rsp_seen == start; i++) @(posedge clk);
        if (rsp_seen == start) begin
            checks++;
            errors++;
            $display("[TB] FAIL response_wait: got no response expected one");
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        int            kind;
        for (int i = 0; i < 64; i++) begin
            ram_model[i] = 32'd0;
            ram_known[i] = 4'd0;
        end
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("lit_leds_reset", {24'd0, leds}, 32'd0);
        $display("[TB] directed scenarios");

        applyStimulus(1'b1, 10'h000, 4'hF, 32'hDEADBEEF);
        applyStimulus(1'b0, 10'h000, 4'h0, 32'd0);
        checkOutput("lit_ram0", last_rdata, 32'hDEADBEEF);
        checkOutput("lit_ram0_err", 32'(last_err), 32'd0);

        applyStimulus(1'b1, 10'h004, 4'hF, 32'h11223344);
        applyStimulus(1'b1, 10'h004, 4'b0010, 32'h0000AA00);
        applyStimulus(1'b0, 10'h004, 4'h0, 32'd0);
        checkOutput("lit_lane_merge", last_rdata, 32'h1122AA44);

        applyStimulus(1'b1, 10'h0F0, 4'b0001, 32'h000000A5);
        checkOutput("lit_leds_a5", {24'd0, leds}, 32'h000000A5);
        applyStimulus(1'b0, 10'h0F0, 4'h0, 32'd0);
        checkOutput("lit_led_read", last_rdata, 32'h000000A5);

        applyStimulus(1'b0, 10'h0FC, 4'h0, 32'd0);
        checkOutput("lit_fc_read_err", 32'(last_err), 32'd1);
        checkOutput("lit_fc_read_data", last_rdata, 32'd0);
        applyStimulus(1'b1, 10'h0FC, 4'hF, 32'hFFFFFFFF);
        checkOutput("lit_fc_write_err", 32'(last_err), 32'd1);
        applyStimulus(1'b0, 10'h0F0, 4'h0, 32'd0);
        checkOutput("lit_led_unchanged", last_rdata, 32'h000000A5);

        applyStimulus(1'b1, 10'h0F4, 4'hF, 32'h55555555);
        checkOutput("lit_cyc_write_err", 32'(last_err), 32'd0);
        applyStimulus(1'b0, 10'h200, 4'h0, 32'd0);
        checkOutput("lit_upper_err", 32'(last_err), 32'd1);

        applyStimulus(1'b1, 10'h010, 4'hF, 32'hCAFEF00D);
        applyStimulus(1'b1, 10'h010, 4'h0, 32'h00000000);
        checkOutput("lit_be0_err", 32'(last_err), 32'd0);
        applyStimulus(1'b0, 10'h010, 4'h0, 32'd0);
        checkOutput("lit_be0_keep", last_rdata, 32'hCAFEF00D);

        // Abort a write in WAIT with reset.
        applyStimulus(1'b1, 10'h008, 4'hF, 32'h00000000);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h008;
        req_be = 4'hF; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("lit_leds_abort", {24'd0, leds}, 32'd0);
        applyStimulus(1'b0, 10'h008, 4'h0, 32'd0);
        checkOutput("lit_abort_ram", last_rdata, 32'h00000000);
        applyStimulus(1'b1, 10'h00C, 4'hF, 32'h0BADC0DE);
        applyStimulus(1'b0, 10'h0F0, 4'h0, 32'd0);
        checkOutput("lit_led_after_rst", last_rdata, 32'd0);
        applyStimulus(1'b0, 10'h0F8, 4'h0, 32'd0);
        checkOutput("lit_txn3", last_rdata, 32'd3);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b1, AW'(i * 4), 4'hF, $urandom);
        end
        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(0, 10));
            if (kind <= 5)       a = AW'($urandom_range(0, 59) * 4);
            else if (kind == 6)  a = 10'h0F0;
            else if (kind == 7)  a = 10'h0F4;
            else if (kind == 8)  a = 10'h0F8;
            else if (kind == 9)  a = 10'h0FC;
            else                 a = AW'($urandom_range(256, 1023));
            a[1:0] = 2'($urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
